fusion_stream_unit: RTL



---
 rtl/fusion_stream_if.sv | 24 ++
 rtl/fusion_stream_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fusion_stream_if.sv
// Handshake bundle for fusion_stream_unit: fetch-side input stream and dispatch-side output stream.
// The unit is the slave of this bundle; the producer/consumer pair is the master.
interface fusion_stream_if #(
    parameter int INST_W = 16
);
    logic [INST_W-1:0] in_inst;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] out_inst;
    logic              out_valid;
    logic              out_ready;
    logic              out_fused;
    logic [1:0]        out_fusion_type;

    modport slave (
        input  in_inst, in_valid, out_ready,
        output in_ready, out_inst, out_valid, out_fused, out_fusion_type
    );

    modport master (
        output in_inst, in_valid, out_ready,
        input  in_ready, out_inst, out_valid, out_fused, out_fusion_type
    );
endinterface

// File: rtl/fusion_stream_unit.sv
// Instruction-fusion stage: small FIFO, head-pair fusion (load/store/compute), bounded partner wait.
// Define FUSION_STATS_EN to build the fusion_count/pass_count statistics counters.
module fusion_stream_unit #(
    parameter int         INST_W    = 16,
    parameter int         DEPTH     = 4,
    parameter int         WAIT_MAX  = 3,
    parameter logic [3:0] OP_LOAD   = 4'h7,
    parameter logic [3:0] OP_STORE  = 4'h6,
    parameter logic [3:0] OP_CUSTOM = 4'hF,
    parameter int         CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fuse_enable,
    input  logic             flush,
    fusion_stream_if.slave   bus,
    output logic [CNT_W-1:0] fusion_count,
    output logic [CNT_W-1:0] pass_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    logic [INST_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [WW-1:0]     wait_cnt;

    logic [INST_W-1:0] h, n;
    logic [3:0]        h_op, n_op, h_func, n_func;
    logic [2:0]        h_rd, n_rd, n_rs;
    logic [1:0]        h_acc, n_acc;

    logic              free, push;
    logic              sel_emit, wait_inc;
    logic [INST_W-1:0] sel_inst;
    logic [1:0]        sel_type;
    logic [1:0]        pop_n;

    assign h      = mem[rd_ptr];
    assign n      = mem[rd_ptr + AW'(1)];
    assign h_op   = h[INST_W-1:INST_W-4];
    assign n_op   = n[INST_W-1:INST_W-4];
    assign h_rd   = h[INST_W-5:INST_W-7];
    assign n_rd   = n[INST_W-5:INST_W-7];
    assign n_rs   = n[INST_W-8:INST_W-10];
    assign h_acc  = h[INST_W-5:INST_W-6];
    assign n_acc  = n[INST_W-5:INST_W-6];
    assign h_func = h[INST_W-7:INST_W-10];
    assign n_func = n[INST_W-7:INST_W-10];

    assign bus.in_ready = (count < CW'(DEPTH)) && !flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign free         = !bus.out_valid || bus.out_ready;

    // Selection is only meaningful in a free cycle; a stalled output freezes the FIFO head.
    always_comb begin
        sel_emit = 1'b0;
        sel_inst = '0;
        sel_type = 2'd0;
        pop_n    = 2'd0;
        wait_inc = 1'b0;
        if (free) begin
            if (count >= CW'(2) && fuse_enable && h_op == OP_LOAD && n_op == OP_CUSTOM
                && h_rd == n_rs) begin
                sel_emit = 1'b1;
                sel_inst = {n[INST_W-1:INST_W-10], h[INST_W-11:0]};
                sel_type = 2'd1;
                pop_n    = 2'd2;
            end else if (count >= CW'(2) && fuse_enable && h_op == OP_CUSTOM
                         && n_op == OP_STORE && h_rd == n_rd) begin
                sel_emit = 1'b1;
                sel_inst = {h[INST_W-1:INST_W-10], n[INST_W-11:0]};
                sel_type = 2'd2;
                pop_n    = 2'd2;
            end else if (count >= CW'(2) && fuse_enable && h_op == OP_CUSTOM
                         && n_op == OP_CUSTOM && h_acc == n_acc) begin
                sel_emit = 1'b1;
                sel_inst = {h[INST_W-1:INST_W-6], h_func | n_func, h[INST_W-11:0]};
                sel_type = 2'd3;
                pop_n    = 2'd2;
            end else if (count == CW'(1) && fuse_enable
                         && (h_op == OP_LOAD || h_op == OP_CUSTOM)
                         && int'(wait_cnt) < WAIT_MAX) begin
                wait_inc = 1'b1;
            end else if (count != '0) begin
                sel_emit = 1'b1;
                sel_inst = h;
                sel_type = 2'd0;
                pop_n    = 2'd1;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by count/pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            wait_cnt            <= '0;
            bus.out_valid       <= 1'b0;
            bus.out_inst        <= '0;
            bus.out_fused       <= 1'b0;
            bus.out_fusion_type <= 2'd0;
        end else if (flush) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            wait_cnt      <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + CW'(push) - CW'(pop_n);
            if (pop_n != 2'd0)  wait_cnt <= '0;
            else if (wait_inc)  wait_cnt <= wait_cnt + WW'(1);
            if (free) begin
                bus.out_valid <= sel_emit;
                if (sel_emit) begin
                    bus.out_inst        <= sel_inst;
                    bus.out_fused       <= (sel_type != 2'd0);
                    bus.out_fusion_type <= sel_type;
                end
            end
        end
    end

`ifdef FUSION_STATS_EN
    // Counters bump on the edge that loads the word into the output register and stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fusion_count <= '0;
            pass_count   <= '0;
        end else if (!flush && sel_emit) begin
            if (sel_type != 2'd0) begin
                if (fusion_count != '1) fusion_count <= fusion_count + CNT_W'(1);
            end else begin
                if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
            end
        end
    end
`else
    assign fusion_count = '0;
    assign pass_count   = '0;
`endif

endmodule
